stopwatch_multilap: RTL and testbench

Parametrised stopwatch engine with a multi-entry lap buffer. It counts MM:SS:CC (centiseconds) from a configurable prescaler. Each lap press captures either the cumulative time or the split since the previous lap into a show-ahead FIFO that the display/UI logic pops one record at a time. It replaces the single-lap stopwatch core in the clock/stopwatch mode path and is driven by the same debounced one-cycle button pulses.

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/sw_time_counter.sv | 56 +++++
 rtl/stopwatch_multilap.sv | 215 +++++++++++++++++++++
 tb/tb_stopwatch_multilap.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared widths, time/lap record types and helpers for the multi-lap stopwatch
package stopwatch_pkg;

    localparam int MIN_W     = 7;
    localparam int SEC_W     = 6;
    localparam int CENTI_W   = 7;
    localparam int LAPNUM_W  = 8;

    localparam int CENTI_MAX = 99;
    localparam int SEC_MAX   = 59;

    typedef struct packed {
        logic [MIN_W-1:0]   min;
        logic [SEC_W-1:0]   sec;
        logic [CENTI_W-1:0] centis;
    } sw_time_t;

    typedef struct packed {
        sw_time_t            t;
        logic [LAPNUM_W-1:0] num;
    } lap_rec_t;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } sw_state_t;

    // Lap numbers are 1-based; 0 is reserved for "no record", so 255 wraps to 1.
    function automatic logic [LAPNUM_W-1:0] next_lap_num(input logic [LAPNUM_W-1:0] n);
        return (n == '1) ? LAPNUM_W'(1) : n + 1'b1;
    endfunction

endpackage

// File: rtl/sw_time_counter.sv
// rtl/sw_time_counter.sv - cascaded MM:SS:CC counter with increment, clear and minute wrap
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - synchronous clear to 00:00:00 (wins over inc_i)
//   inc_i     - advance by one centisecond
//   time_o    - current MM:SS:CC value
module sw_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 99
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr_i,
    input  logic     inc_i,
    output sw_time_t time_o
);

    localparam logic [MIN_W-1:0]   MIN_LAST   = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_MAX);
    localparam logic [CENTI_W-1:0] CENTI_LAST = CENTI_W'(CENTI_MAX);

    sw_time_t time_q, time_d;

    always_comb begin
        time_d = time_q;
        if (clr_i) begin
            time_d = '0;
        end else if (inc_i) begin
            if (time_q.centis != CENTI_LAST) begin
                time_d.centis = time_q.centis + 1'b1;
            end else begin
                time_d.centis = '0;
                if (time_q.sec != SEC_LAST) begin
                    time_d.sec = time_q.sec + 1'b1;
                end else begin
                    time_d.sec = '0;
                    // MIN_MAX:59:99 rolls silently to 00:00:00.
                    time_d.min = (time_q.min == MIN_LAST) ? '0 : time_q.min + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_o = time_q;

endmodule

// File: rtl/stopwatch_multilap.sv
// rtl/stopwatch_multilap.sv - stopwatch engine with prescaler, total/split counters and show-ahead lap FIFO
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   enable                      - stopwatch mode active; low holds the block cleared
//   start_stop_p, lap_p,
//   clear_p, rd_p               - one-cycle control pulses
//   delta_mode                  - lap records split (1) or cumulative (0) time
//   running                     - count active
//   cur_min/cur_sec/cur_centis  - live cumulative time
//   lap_min/lap_sec/lap_centis,
//   lap_idx                     - FIFO head record, zero when empty
//   lap_empty, lap_full,
//   lap_count, lap_overflow     - FIFO status, overflow is sticky until cleared
module stopwatch_multilap
    import stopwatch_pkg::*;
#(
    parameter int CLK_PER_CENTI = 10,
    parameter int LAP_DEPTH     = 8,
    parameter int MIN_MAX       = 99
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       start_stop_p,
    input  logic                       lap_p,
    input  logic                       clear_p,
    input  logic                       delta_mode,
    input  logic                       rd_p,
    output logic                       running,
    output logic [MIN_W-1:0]           cur_min,
    output logic [SEC_W-1:0]           cur_sec,
    output logic [CENTI_W-1:0]         cur_centis,
    output logic [MIN_W-1:0]           lap_min,
    output logic [SEC_W-1:0]           lap_sec,
    output logic [CENTI_W-1:0]         lap_centis,
    output logic [LAPNUM_W-1:0]        lap_idx,
    output logic                       lap_empty,
    output logic                       lap_full,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       lap_overflow
);

    localparam int PTR_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = $clog2(CLK_PER_CENTI);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_CENTI - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LAP_DEPTH);

    logic clear_w, ss_go, lap_go, rd_go;
    logic running_w, tick_w;

    sw_state_t state_q, state_d;

    logic [PRE_W-1:0] presc_q, presc_d;

    sw_time_t total_t, split_t;

    lap_rec_t            lap_mem_q [LAP_DEPTH];
    lap_rec_t            rec_w, head_w;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LAPNUM_W-1:0] lapnum_q, lapnum_d;
    logic                ovf_q, ovf_d;
    logic                full_w, empty_w, push_w, pop_w;

    // Any clear source masks every other pulse in the same cycle.
    assign clear_w = !enable || clear_p;
    assign ss_go   = start_stop_p && !clear_w;
    assign lap_go  = lap_p && !clear_w;
    assign rd_go   = rd_p && !clear_w;

    // Run/stop state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_w) begin
            state_d = ST_STOPPED;
        end else if (ss_go) begin
            case (state_q)
                ST_STOPPED: state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_STOPPED;
                default:    state_d = ST_STOPPED;
            endcase
        end
    end

    assign running_w = (state_q == ST_RUNNING);

    // Prescaler parks at 0 while stopped so a restart always waits a full period.
    assign tick_w = running_w && (presc_q == PRE_LAST);

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (clear_w || !running_w || tick_w) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    sw_time_counter #(.MIN_MAX(MIN_MAX)) u_total (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear_w),
        .inc_i  (tick_w),
        .time_o (total_t)
    );

    // Every lap press restarts the split, even when its record is dropped.
    sw_time_counter #(.MIN_MAX(MIN_MAX)) u_split (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear_w || lap_go),
        .inc_i  (tick_w),
        .time_o (split_t)
    );

    // Lap FIFO. Records sample the registered counters, i.e. the pre-tick value.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    assign pop_w   = rd_go && !empty_w;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the lap.
    assign push_w  = lap_go && (!full_w || pop_w);

    always_comb begin
        rec_w.t   = delta_mode ? split_t : total_t;
        rec_w.num = next_lap_num(lapnum_q);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lapnum_d = lapnum_q;
        ovf_d    = ovf_q;
        if (clear_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            lapnum_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                lapnum_d = rec_w.num;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (lap_go && !push_w) begin
                ovf_d = 1'b1;
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lapnum_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lapnum_q <= lapnum_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_w) begin
            lap_mem_q[wr_ptr_q] <= rec_w;
        end
    end

    assign head_w = lap_mem_q[rd_ptr_q];

    assign running      = running_w;
    assign cur_min      = total_t.min;
    assign cur_sec      = total_t.sec;
    assign cur_centis   = total_t.centis;
    assign lap_min      = empty_w ? '0 : head_w.t.min;
    assign lap_sec      = empty_w ? '0 : head_w.t.sec;
    assign lap_centis   = empty_w ? '0 : head_w.t.centis;
    assign lap_idx      = empty_w ? '0 : head_w.num;
    assign lap_empty    = empty_w;
    assign lap_full     = full_w;
    assign lap_count    = count_q;
    assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_multilap.sv
// tb/tb_stopwatch_multilap.sv - self-checking bench for stopwatch_multilap
module tb_stopwatch_multilap;

    localparam int CPC   = 3;
    localparam int DEPTH = 8;
    localparam int MAXM  = 99;

    logic clk = 1'b0;
    logic rst, enable, start_stop_p, lap_p, clear_p, delta_mode, rd_p;
    logic running;
    logic [6:0] cur_min, cur_centis, lap_min, lap_centis;
    logic [5:0] cur_sec, lap_sec;
    logic [7:0] lap_idx;
    logic lap_empty, lap_full, lap_overflow;
    logic [3:0] lap_count;

    logic en2, ss2;
    logic zero2 = 1'b0;
    logic running2;
    logic [6:0] cur_min2, cur_centis2, lap_min2, lap_centis2;
    logic [5:0] cur_sec2, lap_sec2;
    logic [7:0] lap_idx2;
    logic lap_empty2, lap_full2, lap_overflow2;
    logic [3:0] lap_count2;

    always #5 clk = ~clk;

    stopwatch_multilap #(.CLK_PER_CENTI(CPC), .LAP_DEPTH(DEPTH), .MIN_MAX(MAXM)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start_stop_p(start_stop_p), .lap_p(lap_p),
        .clear_p(clear_p), .delta_mode(delta_mode), .rd_p(rd_p), .running(running),
        .cur_min(cur_min), .cur_sec(cur_sec), .cur_centis(cur_centis),
        .lap_min(lap_min), .lap_sec(lap_sec), .lap_centis(lap_centis), .lap_idx(lap_idx),
        .lap_empty(lap_empty), .lap_full(lap_full), .lap_count(lap_count),
        .lap_overflow(lap_overflow)
    );

    // Second instance with MIN_MAX=0 so the full-scale wrap is reachable quickly.
    stopwatch_multilap #(.CLK_PER_CENTI(2), .LAP_DEPTH(DEPTH), .MIN_MAX(0)) dut_wrap (
        .clk(clk), .rst(rst), .enable(en2), .start_stop_p(ss2), .lap_p(zero2),
        .clear_p(zero2), .delta_mode(zero2), .rd_p(zero2), .running(running2),
        .cur_min(cur_min2), .cur_sec(cur_sec2), .cur_centis(cur_centis2),
        .lap_min(lap_min2), .lap_sec(lap_sec2), .lap_centis(lap_centis2), .lap_idx(lap_idx2),
        .lap_empty(lap_empty2), .lap_full(lap_full2), .lap_count(lap_count2),
        .lap_overflow(lap_overflow2)
    );

    typedef struct {
        int ticks;
        bit clr;
        bit lap;
        bit delta;
        bit rd;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    vec_t tbl [40];
    int   ntbl = 0;

    int errors = 0;
    int checks = 0;

    // Reference model: centisecond totals, lap numbering and expected FIFO contents.
    int m_total = 0;
    int m_split = 0;
    int m_idx   = 0;
    logic [27:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] to_time(input int t);
        int m;
        m = (t / 6000) % (MAXM + 1);
        return {7'(m), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    task automatic model_clear();
        m_total = 0;
        m_split = 0;
        m_idx   = 0;
        sb.delete();
    endtask

    // Runs exactly n ticks from a stopped state and stops again.
    task automatic run_ticks(input int n);
        start_stop_p = 1'b1;
        cyc(1);
        start_stop_p = 1'b0;
        cyc(n * CPC - 1);
        start_stop_p = 1'b1;
        cyc(1);
        start_stop_p = 1'b0;
        m_total += n;
        m_split += n;
    endtask

    task automatic op(input bit lap, input bit delta, input bit rd);
        logic [27:0] rec;
        bit full, pop, push;
        full = (sb.size() == DEPTH);
        pop  = rd && (sb.size() != 0);
        push = lap && (!full || pop);
        rec  = {to_time(delta ? m_split : m_total), 8'd0};
        if (pop) void'(sb.pop_front());
        if (push) begin
            m_idx = (m_idx == 255) ? 1 : m_idx + 1;
            rec[7:0] = 8'(m_idx);
            sb.push_back(rec);
        end
        if (lap) m_split = 0;
        lap_p = lap;
        delta_mode = delta;
        rd_p = rd;
        cyc(1);
        lap_p = 1'b0;
        rd_p = 1'b0;
    endtask

    task automatic check_head(input string name);
        logic [27:0] exp;
        exp = (sb.size() != 0) ? sb[0] : 28'd0;
        chk(name, {lap_min, lap_sec, lap_centis, lap_idx}, exp);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_cur"}, {cur_min, cur_sec, cur_centis}, 0);
        chk({name, "_run"}, running, 0);
        chk({name, "_head"}, {lap_min, lap_sec, lap_centis, lap_idx}, 0);
        chk({name, "_cnt"}, lap_count, 0);
        chk({name, "_empty"}, lap_empty, 1);
        chk({name, "_full"}, lap_full, 0);
        chk({name, "_ovf"}, lap_overflow, 0);
    endtask

    task automatic add(input int ticks, input bit clr, input bit lap, input bit delta,
                       input bit rd, input int cnt, input bit ovf);
        tbl[ntbl] = '{ticks, clr, lap, delta, rd, cnt, ovf};
        ntbl++;
    endtask

    task automatic raw_lap();
        lap_p = 1'b1;
        cyc(1);
        lap_p = 1'b0;
        cyc(2);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; start_stop_p = 1'b0; lap_p = 1'b0; clear_p = 1'b0;
        delta_mode = 1'b0; rd_p = 1'b0; en2 = 1'b1; ss2 = 1'b0;

        #12;
        check_zero("reset");
        rst = 1'b0;
        cyc(1);

        // Long run: first-tick latency, 10 000 ticks, then a frozen stop.
        start_stop_p = 1'b1;
        cyc(1);
        start_stop_p = 1'b0;
        chk("run_started", running, 1);
        cyc(CPC - 1);
        chk("pre_first_tick", {cur_min, cur_sec, cur_centis}, to_time(0));
        cyc(1);
        chk("first_tick", {cur_min, cur_sec, cur_centis}, to_time(1));
        cyc(10000 * CPC - CPC - 1);
        chk("t9999", {cur_min, cur_sec, cur_centis}, to_time(9999));
        chk("t9999_run", running, 1);
        start_stop_p = 1'b1;
        cyc(1);
        start_stop_p = 1'b0;
        chk("t10000", {cur_min, cur_sec, cur_centis}, to_time(10000));
        chk("stopped", running, 0);
        cyc(500);
        chk("held", {cur_min, cur_sec, cur_centis}, 20'h0_14_00 | to_time(10000));

        // ticks, clr, lap, delta, rd, expected count, expected overflow
        add(150, 1, 1, 0, 0, 1, 0);
        add(150, 0, 1, 0, 0, 2, 0);
        add(0,   0, 0, 0, 1, 1, 0);
        add(0,   0, 0, 0, 1, 0, 0);
        add(0,   0, 0, 0, 1, 0, 0);
        add(200, 1, 1, 1, 0, 1, 0);
        add(330, 0, 1, 1, 0, 2, 0);
        add(0,   0, 0, 0, 1, 1, 0);
        add(0,   0, 0, 0, 1, 0, 0);
        add(0,   1, 1, 0, 1, 1, 0);
        for (int c = 2; c <= 9; c++) add(1, 0, 1, 0, 0, (c > 8) ? 8 : c, c > 8);
        add(0,   0, 1, 0, 1, 8, 1);
        for (int c = 7; c >= 0; c--) add(0, 0, 0, 0, 1, c, 1);
        add(0,   1, 0, 0, 0, 0, 0);

        for (int i = 0; i < ntbl; i++) begin
            if (tbl[i].clr) begin
                clear_p = 1'b1;
                cyc(1);
                clear_p = 1'b0;
                model_clear();
            end
            if (tbl[i].ticks > 0) run_ticks(tbl[i].ticks);
            if (tbl[i].lap || tbl[i].rd) op(tbl[i].lap, tbl[i].delta, tbl[i].rd);
            chk($sformatf("v%0d_cnt", i), lap_count, tbl[i].exp_cnt);
            chk($sformatf("v%0d_full", i), lap_full, tbl[i].exp_cnt == DEPTH);
            chk($sformatf("v%0d_empty", i), lap_empty, tbl[i].exp_cnt == 0);
            chk($sformatf("v%0d_ovf", i), lap_overflow, tbl[i].exp_ovf);
            check_head($sformatf("v%0d_head", i));
        end

        // clear_p beats a coincident lap and start; numbering restarts at 1.
        run_ticks(40);
        op(1, 0, 0);
        op(1, 0, 0);
        chk("pre_clr_cnt", lap_count, 2);
        clear_p = 1'b1; lap_p = 1'b1; start_stop_p = 1'b1;
        cyc(1);
        clear_p = 1'b0; lap_p = 1'b0; start_stop_p = 1'b0;
        model_clear();
        check_zero("clr_lap");
        op(1, 0, 0);
        check_head("post_clr_head");

        // Lap number wrap 255 -> 1 using lap+rd pairs.
        clear_p = 1'b1;
        cyc(1);
        clear_p = 1'b0;
        model_clear();
        for (int k = 0; k < 255; k++) op(1, 0, 1);
        check_head("idx255_head");
        op(1, 0, 1);
        check_head("idx_wrap_head");
        chk("idx_wrap_cnt", lap_count, 1);

        // Asynchronous reset mid-count with three records stored.
        clear_p = 1'b1;
        cyc(1);
        clear_p = 1'b0;
        start_stop_p = 1'b1;
        cyc(1);
        start_stop_p = 1'b0;
        cyc(7);
        raw_lap(); raw_lap(); raw_lap();
        chk("rst_pre_cnt", lap_count, 3);
        chk("rst_pre_run", running, 1);
        #3 rst = 1'b1;
        #1 check_zero("rst_async");
        #10 rst = 1'b0;
        cyc(1);
        chk("rst_after_run", running, 0);

        // One-cycle enable drop acts as a full clear and masks the start pulse.
        start_stop_p = 1'b1;
        cyc(1);
        start_stop_p = 1'b0;
        cyc(5);
        raw_lap(); raw_lap(); raw_lap();
        chk("en_pre_cnt", lap_count, 3);
        enable = 1'b0; start_stop_p = 1'b1;
        cyc(1);
        enable = 1'b1; start_stop_p = 1'b0;
        check_zero("en_drop");
        model_clear();

        // Full-scale wrap on the MIN_MAX=0 instance: 00:59:99 -> 00:00:00.
        ss2 = 1'b1;
        cyc(1);
        ss2 = 1'b0;
        cyc(5999 * 2);
        chk("wrap_last", {cur_min2, cur_sec2, cur_centis2}, {7'd0, 6'd59, 7'd99});
        cyc(2);
        chk("wrap_zero", {cur_min2, cur_sec2, cur_centis2}, 20'd0);
        chk("wrap_run", running2, 1);
        chk("wrap_empty", lap_empty2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
